interrupter: RTL and testbench

Burst/pulse interrupter for the DRSSTC controller, downstream of the UART config receiver. Consumes the five 8-bit configuration bytes (CONF_PAR_0..CONF_PAR_4) and produces the bridge-driver gate enable `int_en`. Supports continuous and burst modes. New settings are applied only at period boundaries, so a partially received UART frame never corrupts a pulse in progress.

---
 rtl/drsstc_pkg.sv | 10 +
 rtl/interrupter_if.sv | 11 +
 rtl/tick_gen.sv | 16 +
 rtl/interrupter.sv | 80 ++++++++
 tb/tb_interrupter.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/drsstc_pkg.sv
// drsstc_pkg: config byte map, config array type and interrupter state encoding
package drsstc_pkg;
    typedef enum int {CONF_PAR_0, CONF_PAR_1, CONF_PAR_2, CONF_PAR_3, CONF_PAR_4} Conf_par;
    localparam int CONF_W = 8;
    typedef logic [CONF_PAR_4:0][CONF_W-1:0] conf_t;
    typedef enum logic [1:0] {IDLE, ON, OFF, GAP} State;
    function automatic logic [CONF_W-1:0] min_b(input logic [CONF_W-1:0] a, input logic [CONF_W-1:0] b);
        return a < b ? a : b;
    endfunction
endpackage

// File: rtl/interrupter_if.sv
// interrupter_if: config/halt inputs and gate-drive outputs of the interrupter
interface interrupter_if;
    import drsstc_pkg::*;
    conf_t conf;
    logic halt;
    logic int_en;
    logic per_strobe;
    logic busy;
    modport master (output conf, halt, input int_en, per_strobe, busy);
    modport slave (input conf, halt, output int_en, per_strobe, busy);
endinterface

// File: rtl/tick_gen.sv
// tick_gen: prescaler emitting a one-cycle tick every TICK_DIV cycles after clr
module tick_gen #(
    parameter int TICK_DIV = 52
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(TICK_DIV);
    logic [W-1:0] cnt_q;
    assign tick = cnt_q == W'(TICK_DIV - 1);
    always_ff @(posedge clk)
        if (!rst_n || clr) cnt_q <= '0;
        else cnt_q <= tick ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/interrupter.sv
// interrupter: continuous/burst gate-enable generator; config is shadowed at period boundaries
module interrupter
    import drsstc_pkg::*;
#(
    parameter int TICK_DIV = 52,
    parameter int ON_MAX   = 20
) (
    input logic clk,
    input logic rst_n,
    interrupter_if.slave bus
);
    localparam logic [CONF_W-1:0] ON_LIM = CONF_W'(ON_MAX);
    State state_q;
    logic [CONF_W-1:0] per_q, on_q, bn_q, gap_q, phase_q, gcnt_q, pulse_q;
    logic burst_q, int_en_q, strobe_q;
    logic [CONF_W-1:0] per_l, on_l, bn_l, on_eff_l;
    logic go, tick, last, per_end, gap_end, to_gap, reload, enter_on, unused_ok;
    assign per_l    = bus.conf[CONF_PAR_1];
    assign on_l     = bus.conf[CONF_PAR_2];
    assign bn_l     = bus.conf[CONF_PAR_3] == '0 ? CONF_W'(1) : bus.conf[CONF_PAR_3];
    assign on_eff_l = min_b(min_b(on_l, ON_LIM), per_l - 1'b1);
    assign go       = bus.conf[CONF_PAR_0][0] && per_l >= CONF_W'(2) && on_l != '0;
    assign unused_ok = ^bus.conf[CONF_PAR_0][CONF_W-1:2];
    // >= rather than == so a shrunken bn at reload still ends the burst
    assign last     = burst_q && pulse_q + 1'b1 >= bn_q;
    assign per_end  = state_q == OFF && tick && phase_q + 1'b1 == per_q;
    assign gap_end  = state_q == GAP && tick && gcnt_q + 1'b1 == gap_q;
    assign to_gap   = per_end && last && gap_q != '0;
    assign reload   = (state_q == IDLE && go) || (per_end && !to_gap) || gap_end;
    assign enter_on = !bus.halt && reload && go;
    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (bus.halt || state_q == IDLE || enter_on),
        .tick (tick)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            {per_q, on_q, bn_q, gap_q, phase_q, gcnt_q, pulse_q} <= '0;
            {burst_q, int_en_q, strobe_q} <= '0;
        end else if (bus.halt) begin
            state_q <= IDLE;
            {phase_q, gcnt_q, pulse_q} <= '0;
            {int_en_q, strobe_q} <= '0;
        end else begin
            strobe_q <= enter_on;
            case (state_q)
                IDLE: pulse_q <= '0;
                ON: if (tick) begin
                    phase_q <= phase_q + 1'b1;
                    if (phase_q + 1'b1 == on_q) begin
                        state_q  <= OFF;
                        int_en_q <= 1'b0;
                    end
                end
                OFF: if (tick) phase_q <= phase_q + 1'b1;
                GAP: if (tick) gcnt_q <= gcnt_q + 1'b1;
            endcase
            if (per_end) pulse_q <= burst_q && !last ? pulse_q + 1'b1 : '0;
            if (to_gap) begin
                state_q <= GAP;
                gcnt_q  <= '0;
            end
            if (reload) begin
                per_q    <= per_l;
                on_q     <= on_eff_l;
                bn_q     <= bn_l;
                gap_q    <= bus.conf[CONF_PAR_4];
                burst_q  <= bus.conf[CONF_PAR_0][1];
                state_q  <= go ? ON : IDLE;
                int_en_q <= go;
                phase_q  <= '0;
            end
        end
    end
    assign bus.int_en     = int_en_q;
    assign bus.per_strobe = strobe_q;
    assign bus.busy       = state_q != IDLE;
endmodule

// File: tb/tb_interrupter.sv
// tb_interrupter: vector table, corner sequences and random run against a cycle-count model
module tb_interrupter;
    import drsstc_pkg::*;
    localparam int TD = 4;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;
    interrupter_if b();
    interrupter_if b5();
    assign b5.conf = b.conf;
    assign b5.halt = b.halt;
    interrupter #(.TICK_DIV(TD), .ON_MAX(20)) dut  (.clk(clk), .rst_n(rst_n), .bus(b.slave));
    interrupter #(.TICK_DIV(TD), .ON_MAX(5))  dut5 (.clk(clk), .rst_n(rst_n), .bus(b5.slave));

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, a, e);
        end
    endtask

    typedef struct {
        logic [7:0] c0, per, on, bn, gap;
        bit m5;
        int hi, lo;
    } vec_t;
    vec_t vt[7];

    // model: everything in cycles since the last strobe, frame = period (+ gap after a burst)
    bit m_ok, m_act, s_burst;
    int m_t, m_pulse, s_on, s_per, s_gap, s_bn;
    function automatic int mn(input int x, input int y);
        return x < y ? x : y;
    endfunction
    function automatic bit live_go();
        return b.conf[0][0] && int'(b.conf[1]) >= 2 && b.conf[2] != 8'd0;
    endfunction
    task automatic m_load();
        s_per   = int'(b.conf[1]) * TD;
        s_on    = mn(mn(int'(b.conf[2]), 20), int'(b.conf[1]) - 1) * TD;
        s_bn    = b.conf[3] == 8'd0 ? 1 : int'(b.conf[3]);
        s_gap   = int'(b.conf[4]) * TD;
        s_burst = b.conf[0][1];
    endtask
    always @(posedge clk) begin
        bit last;
        m_ok = 1'b1;
        if (!rst_n || b.halt) m_act = 1'b0;
        else if (!m_act) begin
            if (live_go()) begin
                m_load();
                m_act = 1'b1;
                m_t = 0;
                m_pulse = 0;
            end
        end else begin
            m_t++;
            last = s_burst && m_pulse + 1 >= s_bn;
            if (m_t == s_per + (last ? s_gap : 0)) begin
                m_pulse = (s_burst && !last) ? m_pulse + 1 : 0;
                m_load();
                if (live_go()) m_t = 0;
                else m_act = 1'b0;
            end
        end
    end
    always @(negedge clk) if (m_ok) begin
        chk("model int_en", b.int_en, m_act && m_t < s_on);
        chk("model per_strobe", b.per_strobe, m_act && m_t == 0);
        chk("model busy", b.busy, m_act);
    end

    function automatic logic st(input bit s); return s ? b5.per_strobe : b.per_strobe; endfunction
    function automatic logic en(input bit s); return s ? b5.int_en : b.int_en; endfunction

    task automatic setc(input logic [7:0] c0, per, on, bn, gap);
        b.conf[0] = c0; b.conf[1] = per; b.conf[2] = on; b.conf[3] = bn; b.conf[4] = gap;
    endtask
    task automatic restart();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask
    task automatic run_vec(input vec_t v);
        int hi, lo;
        b.halt = 1'b0;
        setc(v.c0, v.per, v.on, v.bn, v.gap);
        restart();
        chk("first strobe latency", st(v.m5), 1);
        hi = 0;
        while (en(v.m5) && hi < 400) begin hi++; @(negedge clk); end
        lo = 0;
        while (!st(v.m5) && lo < 400) begin lo++; @(negedge clk); end
        chk("on cycles", hi, v.hi);
        chk("off cycles", lo, v.lo);
    endtask

    initial begin
        int iv[5];
        int n, hi, cnt;
        iv = '{40, 40, 60, 40, 40};
        b.conf = '0;
        b.halt = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset int_en", b.int_en, 0);
        chk("reset per_strobe", b.per_strobe, 0);
        chk("reset busy", b.busy, 0);

        vt[0] = '{8'h01, 8'd10, 8'd3,  8'd0, 8'd0, 1'b0, 12, 28};
        vt[1] = '{8'h01, 8'd10, 8'd15, 8'd0, 8'd0, 1'b0, 36, 4};
        vt[2] = '{8'h01, 8'd10, 8'd8,  8'd0, 8'd0, 1'b1, 20, 20};
        vt[3] = '{8'h03, 8'd10, 8'd2,  8'd3, 8'd5, 1'b0, 8, 32};
        vt[4] = '{8'h01, 8'd2,  8'd1,  8'd0, 8'd0, 1'b0, 4, 4};
        vt[5] = '{8'h01, 8'd5,  8'd9,  8'd0, 8'd0, 1'b0, 16, 4};
        vt[6] = '{8'h03, 8'd4,  8'd1,  8'd0, 8'd0, 1'b0, 4, 12};
        for (int i = 0; i < 7; i++) run_vec(vt[i]);

        setc(8'h03, 8'd10, 8'd2, 8'd3, 8'd5);
        restart();
        for (int k = 0; k < 5; k++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!b.per_strobe && n < 200);
            chk("burst strobe interval", n, iv[k]);
        end

        setc(8'h01, 8'd10, 8'd3, 8'd0, 8'd0);
        restart();
        hi = 0;
        while (b.int_en && hi < 400) begin hi++; if (hi == 3) b.conf[2] = 8'd6; @(negedge clk); end
        chk("rewrite current pulse", hi, 12);
        n = 0;
        while (!b.per_strobe && n < 400) begin n++; @(negedge clk); end
        hi = 0;
        while (b.int_en && hi < 400) begin hi++; @(negedge clk); end
        chk("rewrite next pulse", hi, 24);

        setc(8'h01, 8'd10, 8'd3, 8'd0, 8'd0);
        restart();
        n = 0;
        while (b.busy && n < 400) begin n++; if (n == 4) b.conf[0] = 8'h00; @(negedge clk); end
        chk("disable busy cycles", n, 40);
        cnt = 0;
        repeat (60) begin if (b.per_strobe || b.busy) cnt++; @(negedge clk); end
        chk("disabled stays idle", cnt, 0);

        setc(8'h01, 8'd10, 8'd3, 8'd0, 8'd0);
        restart();
        repeat (3) @(negedge clk);
        b.halt = 1'b1;
        @(negedge clk);
        chk("halt int_en", b.int_en, 0);
        chk("halt busy", b.busy, 0);
        @(negedge clk);
        b.halt = 1'b0;
        @(negedge clk);
        chk("restart after halt", b.per_strobe, 1);

        restart();
        repeat (20) @(negedge clk);
        chk("mid-OFF int_en", b.int_en, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset mid-OFF outputs", {b.int_en, b.per_strobe, b.busy}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart after reset", b.per_strobe, 1);

        setc(8'h01, 8'd1, 8'd3, 8'd0, 8'd0);
        restart();
        cnt = 0;
        repeat (50) begin if (b.busy) cnt++; @(negedge clk); end
        chk("per 1 never starts", cnt, 0);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 59) == 0)
                setc(8'($urandom_range(0, 1) << 1) | 8'($urandom_range(0, 7) != 0),
                     8'($urandom_range(0, 12)), 8'($urandom_range(0, 14)),
                     8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)));
            b.halt = $urandom_range(0, 199) == 0;
            rst_n  = $urandom_range(0, 499) != 0;
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
